// File: rtl/reduce_tree_pipe.sv
// rtl/reduce_tree_pipe.sv - pipelined 4-ary reduction tree (OR/AND/XOR/NOR) with valid/ready flow control
// Optional packet accumulate stage after the tree, enabled by macro REDUCE_ACCUM_EN.
module reduce_tree_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
`ifdef REDUCE_ACCUM_EN
    input  logic             in_last,
`endif
    output logic             in_ready,
    output logic             out_result,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;

    // Number of 4-input nodes produced by tree level lvl-1 (lvl_width(0) is the operand).
    function automatic int lvl_width(input int lvl);
        int w;
        w = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

    function automatic int num_levels();
        int w;
        int n;
        w = WIDTH;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (w > 1) begin
                w = (w + 3) / 4;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic int stage_offset(input int lvl);
        int o;
        o = 0;
        for (int i = 0; i < lvl; i++) begin
            o = o + lvl_width(i + 1);
        end
        return o;
    endfunction

    function automatic logic combine4(input logic [3:0] q, input logic [1:0] mode);
        case (mode)
            MODE_AND: return &q;
            MODE_XOR: return ^q;
            default:  return |q;
        endcase
    endfunction

    localparam int LEVELS  = num_levels();
    localparam int TOTAL_W = stage_offset(LEVELS);

`ifdef REDUCE_ACCUM_EN
    localparam int ACCUM_ON = 1;
`else
    localparam int ACCUM_ON = 0;
`endif

    // The last tree stage only needs to carry its mode forward when the accumulator consumes it.
    localparam int MODE_SLOTS = ((LEVELS - 1 + ACCUM_ON) > 0) ? (LEVELS - 1 + ACCUM_ON) : 1;

    logic w_stall;
    logic w_advance;

    logic [TOTAL_W-1:0]      w_stage_data;
    logic [2*MODE_SLOTS-1:0] w_stage_mode;
    logic [LEVELS-1:0]       w_stage_valid;
`ifdef REDUCE_ACCUM_EN
    logic [LEVELS-1:0]       w_stage_last;
`endif

    assign w_stall   = out_valid && !out_ready;
    assign w_advance = !w_stall;
    assign in_ready  = w_advance;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IW = lvl_width(l);
        localparam int OW = lvl_width(l + 1);
        localparam int PW = 4 * OW;
        localparam bit IS_LAST = (l == LEVELS - 1);

        logic [IW-1:0] w_in;
        logic [1:0]    w_mode_in;
        logic          w_valid_in;
        logic [PW-1:0] w_pad;
        logic [OW-1:0] w_comb;
        logic [OW-1:0] r_data;
        logic          r_valid;
`ifdef REDUCE_ACCUM_EN
        logic          w_last_in;
        logic          r_last;
`endif

        if (l == 0) begin : g_head
            assign w_in       = in_data;
            assign w_mode_in  = in_mode;
            assign w_valid_in = in_valid;
`ifdef REDUCE_ACCUM_EN
            assign w_last_in  = in_last;
`endif
        end else begin : g_body
            assign w_in       = w_stage_data[stage_offset(l - 1) +: IW];
            assign w_mode_in  = w_stage_mode[2*(l-1) +: 2];
            assign w_valid_in = w_stage_valid[l-1];
`ifdef REDUCE_ACCUM_EN
            assign w_last_in  = w_stage_last[l-1];
`endif
        end

        // Padding lanes take the identity of the beat's own mode.
        always_comb begin
            w_pad = {PW{w_mode_in == MODE_AND}};
            w_pad[IW-1:0] = w_in;
        end

        always_comb begin
            w_comb = '0;
            for (int n = 0; n < OW; n++) begin
                w_comb[n] = combine4(w_pad[4*n +: 4], w_mode_in);
            end
            if (IS_LAST && (w_mode_in == MODE_NOR)) begin
                w_comb = ~w_comb;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_data  <= '0;
`ifdef REDUCE_ACCUM_EN
                r_last  <= 1'b0;
`endif
            end else if (w_advance) begin
                r_valid <= w_valid_in;
                r_data  <= w_comb;
`ifdef REDUCE_ACCUM_EN
                r_last  <= w_last_in;
`endif
            end
        end

        if (!IS_LAST || (ACCUM_ON == 1)) begin : g_mode
            logic [1:0] r_mode;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mode <= MODE_OR;
                end else if (w_advance) begin
                    r_mode <= w_mode_in;
                end
            end

            assign w_stage_mode[2*l +: 2] = r_mode;
        end

        assign w_stage_data[stage_offset(l) +: OW] = r_data;
        assign w_stage_valid[l] = r_valid;
`ifdef REDUCE_ACCUM_EN
        assign w_stage_last[l]  = r_last;
`endif
    end

    logic w_tree_valid;
    logic w_tree_result;

    assign w_tree_valid  = w_stage_valid[LEVELS-1];
    assign w_tree_result = w_stage_data[TOTAL_W-1];

`ifdef REDUCE_ACCUM_EN
    logic [1:0] w_tree_mode;
    logic       w_tree_last;
    logic [1:0] w_pkt_mode;
    logic       w_acc_src;
    logic       w_acc_next;

    logic       r_acc;
    logic [1:0] r_acc_mode;
    logic       r_in_pkt;
    logic       r_out_valid;
    logic       r_out_result;

    assign w_tree_mode = w_stage_mode[2*(LEVELS-1) +: 2];
    assign w_tree_last = w_stage_last[LEVELS-1];

    // A packet's first beat merges with the identity of its own mode; zero flags merge by AND.
    always_comb begin
        w_pkt_mode = r_in_pkt ? r_acc_mode : w_tree_mode;
        w_acc_src  = r_in_pkt ? r_acc : ((w_pkt_mode == MODE_AND) || (w_pkt_mode == MODE_NOR));
        case (w_pkt_mode)
            MODE_AND, MODE_NOR: w_acc_next = w_acc_src & w_tree_result;
            MODE_XOR:           w_acc_next = w_acc_src ^ w_tree_result;
            default:            w_acc_next = w_acc_src | w_tree_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= 1'b0;
            r_acc_mode   <= MODE_OR;
            r_in_pkt     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_tree_valid && w_tree_last;
            if (w_tree_valid) begin
                if (w_tree_last) begin
                    r_out_result <= w_acc_next;
                    r_acc        <= 1'b0;
                    r_in_pkt     <= 1'b0;
                end else begin
                    r_acc      <= w_acc_next;
                    r_acc_mode <= w_pkt_mode;
                    r_in_pkt   <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
`else
    assign out_valid  = w_tree_valid;
    assign out_result = w_tree_result;
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// tb/tb_reduce_tree_pipe.sv - directed table-driven bench for reduce_tree_pipe (WIDTH=32 and WIDTH=10)
module tb_reduce_tree_pipe;

`ifdef REDUCE_ACCUM_EN
    localparam int LAT   = 4;
    localparam int LAT10 = 3;
`else
    localparam int LAT   = 3;
    localparam int LAT10 = 2;
`endif

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        in_valid;
    logic        in_ready;
    logic        out_result;
    logic        out_valid;
    logic        out_ready;
`ifdef REDUCE_ACCUM_EN
    logic        in_last;
    logic        last10;
`endif

    logic [9:0]  d10;
    logic [1:0]  m10;
    logic        v10;
    logic        rdy10;
    logic        res10;
    logic        ov10;
    logic        ordy10;

    reduce_tree_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_valid   (in_valid),
`ifdef REDUCE_ACCUM_EN
        .in_last    (in_last),
`endif
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    reduce_tree_pipe #(.WIDTH(10)) dut10 (
        .clk        (clk),
        .reset      (reset),
        .in_data    (d10),
        .in_mode    (m10),
        .in_valid   (v10),
`ifdef REDUCE_ACCUM_EN
        .in_last    (last10),
`endif
        .in_ready   (rdy10),
        .out_result (res10),
        .out_valid  (ov10),
        .out_ready  (ordy10)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic q_res[$];
    int   q_cyc[$];
    int   a_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            q_res.push_back(out_result);
            q_cyc.push_back(cyc);
        end
        if (in_valid === 1'b1 && in_ready === 1'b1 && reset === 1'b0) begin
            a_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_res.delete();
        q_cyc.delete();
        a_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [12];
        vec_t vs [8];
        vec_t vw [5];
        logic held;
        bit   seen;
        int   lat;
        logic got;

        vt[0]  = '{2'b11, 32'h0000_0000, 1'b1};
        vt[1]  = '{2'b11, 32'h0001_0000, 1'b0};
        vt[2]  = '{2'b01, 32'hFFFF_FFFF, 1'b1};
        vt[3]  = '{2'b01, 32'hFFFF_FFFE, 1'b0};
        vt[4]  = '{2'b10, 32'h0000_0007, 1'b1};
        vt[5]  = '{2'b00, 32'h0000_0000, 1'b0};
        vt[6]  = '{2'b00, 32'h8000_0000, 1'b1};
        vt[7]  = '{2'b10, 32'hFFFF_FFFF, 1'b0};
        vt[8]  = '{2'b10, 32'h8000_0001, 1'b0};
        vt[9]  = '{2'b10, 32'h0010_0000, 1'b1};
        vt[10] = '{2'b01, 32'h7FFF_FFFF, 1'b0};
        vt[11] = '{2'b11, 32'hFFFF_FFFF, 1'b0};

        vs[0] = '{2'b00, 32'h0000_0001, 1'b1};
        vs[1] = '{2'b00, 32'h0000_0000, 1'b0};
        vs[2] = '{2'b01, 32'hFFFF_FFFF, 1'b1};
        vs[3] = '{2'b10, 32'h0000_0003, 1'b0};
        vs[4] = '{2'b11, 32'h0000_0000, 1'b1};
        vs[5] = '{2'b10, 32'h0000_0001, 1'b1};
        vs[6] = '{2'b01, 32'hFFFF_0000, 1'b0};
        vs[7] = '{2'b00, 32'h0000_0100, 1'b1};

        vw[0] = '{2'b01, 32'h0000_03FF, 1'b1};
        vw[1] = '{2'b01, 32'h0000_01FF, 1'b0};
        vw[2] = '{2'b00, 32'h0000_0200, 1'b1};
        vw[3] = '{2'b10, 32'h0000_03FF, 1'b0};
        vw[4] = '{2'b00, 32'h0000_0000, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;
        v10       = 1'b0;
        m10       = 2'b00;
        d10       = '0;
        ordy10    = 1'b1;
`ifdef REDUCE_ACCUM_EN
        in_last   = 1'b1;
        last10    = 1'b1;
`endif

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 1'b0);
        chk("rst_w10_out_valid", ov10, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1'b1);
        step();
        clear_q();

        // Back-to-back vectors with mode changes between beats
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_mode  = vt[i].mode;
            in_data  = vt[i].data;
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 3) step();
        chk("tbl_count", q_res.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < q_res.size() && i < a_cyc.size()) begin
                chk($sformatf("tbl_result[%0d]", i), q_res[i], vt[i].exp);
                chk($sformatf("tbl_latency[%0d]", i), q_cyc[i] - a_cyc[i], LAT);
            end
        end
        if (q_cyc.size() >= 2 && a_cyc.size() >= 1) begin
            chk("second_out_after_first_accept", q_cyc[1] - a_cyc[0], LAT + 1);
        end

        // Back-pressure: out_ready low for 5 cycles while beats keep arriving
        clear_q();
        fork
            begin : drv
                bit acc;
                int tries;
                for (int i = 0; i < 8; i++) begin
                    in_valid = 1'b1;
                    in_mode  = vs[i].mode;
                    in_data  = vs[i].data;
                    acc      = 1'b0;
                    tries    = 0;
                    while (!acc && tries < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        tries++;
                        @(posedge clk);
                        #1;
                    end
                    if (!acc) chk($sformatf("stall_accept_timeout[%0d]", i), 0, 1);
                end
                in_valid = 1'b0;
            end
            begin : bp
                bit vseen;
                vseen = 1'b0;
                for (int t = 0; t < 20 && !vseen; t++) begin
                    @(negedge clk);
                    vseen = out_valid;
                end
                chk("stall_first_out_valid", vseen, 1'b1);
                step();
                out_ready = 1'b0;
                @(negedge clk);
                held = out_result;
                chk("stall_in_ready[0]", in_ready, 1'b0);
                chk("stall_out_valid[0]", out_valid, 1'b1);
                for (int k = 1; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("stall_in_ready[%0d]", k), in_ready, 1'b0);
                    chk($sformatf("stall_result_hold[%0d]", k), out_result, held);
                end
                step();
                out_ready = 1'b1;
            end
        join
        repeat (LAT + 4) step();
        chk("stall_count", q_res.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_res.size()) chk($sformatf("stall_result[%0d]", i), q_res[i], vs[i].exp);
        end

        // Reset with beats in flight, in_valid held high across the reset edge
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_data  = 32'h0000_0001;
            step();
        end
        reset = 1'b1;
        step();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_ready_after_reset", in_ready, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < LAT + 4; t++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("flush_no_out_valid", seen, 1'b0);
        chk("flush_no_output", q_res.size(), 0);
        step();
        clear_q();
        in_valid = 1'b1;
        in_mode  = 2'b01;
        in_data  = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        repeat (LAT + 3) step();
        chk("post_reset_count", q_res.size(), 1);
        if (q_res.size() >= 1 && a_cyc.size() >= 1) begin
            chk("post_reset_result", q_res[0], 1'b1);
            chk("post_reset_latency", q_cyc[0] - a_cyc[0], LAT);
        end

        // WIDTH=10: padding identity and latency
        for (int i = 0; i < 5; i++) begin
            m10 = vw[i].mode;
            d10 = vw[i].data[9:0];
            v10 = 1'b1;
            step();
            v10  = 1'b0;
            seen = 1'b0;
            lat  = 0;
            got  = 1'b0;
            for (int t = 1; t <= 10 && !seen; t++) begin
                @(negedge clk);
                if (ov10 === 1'b1) begin
                    seen = 1'b1;
                    lat  = t;
                    got  = res10;
                end
            end
            chk($sformatf("w10_result[%0d]", i), got, vw[i].exp);
            chk($sformatf("w10_latency[%0d]", i), lat, LAT10);
        end
        step();

`ifdef REDUCE_ACCUM_EN
        // Packet 0x0, 0x0, 0x8 then single-beat packet 0x0, all mode OR
        clear_q();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_data  = (i == 2) ? 32'h0000_0008 : 32'h0000_0000;
            in_last  = (i >= 2);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b1;
        repeat (LAT + 4) step();
        chk("acc_count", q_res.size(), 2);
        if (q_res.size() >= 2) begin
            chk("acc_packet_result", q_res[0], 1'b1);
            chk("acc_single_result", q_res[1], 1'b0);
        end
        if (q_cyc.size() >= 1 && a_cyc.size() >= 3) begin
            chk("acc_latency", q_cyc[0] - a_cyc[2], LAT);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reduce_tree_pipe.md
REDUCE_TREE_PIPE -- requirements
Module: reduce_tree_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width, legal range 4..256.
REQ-002 Derived constant LEVELS SHALL equal ceil(log4(WIDTH)); it is 3 for WIDTH=32.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port in_data, input, WIDTH bits, SHALL carry the operand word.
REQ-006 Port in_mode, input, 2 bits, SHALL select the reduction: 00 OR, 01 AND, 10 XOR, 11 NOR (zero flag).
REQ-007 Port in_valid, input, 1 bit, SHALL qualify in_data and in_mode.
REQ-008 Port in_ready, output, 1 bit, SHALL indicate the block accepts a beat this cycle.
REQ-009 Port out_result, output, 1 bit, SHALL carry the reduced bit.
REQ-010 Port out_valid, output, 1 bit, SHALL qualify out_result.
REQ-011 Port out_ready, input, 1 bit, SHALL indicate the sink accepts out_result.

Function
REQ-012 The reduction SHALL be a tree of 4-input combine nodes, one registered tree level per pipeline stage.
REQ-013 A beat SHALL be accepted when in_valid && in_ready are both high in the same cycle.
REQ-014 in_mode SHALL travel with its beat through every stage; mode changes between consecutive beats SHALL NOT affect beats already in flight.
REQ-015 Each level SHALL combine with OR for modes 00/11, AND for 01, and XOR for 10.
REQ-016 Mode 11 SHALL invert the final OR in the last stage.
REQ-017 Lanes padding WIDTH up to the next multiple of 4 SHALL take the identity value: 1 for AND, 0 otherwise.
REQ-018 Latency SHALL be LEVELS cycles from acceptance to out_valid, in the absence of stalls.
REQ-019 stall SHALL be defined as out_valid && !out_ready.
REQ-020 While stall is high, all stages SHALL hold and in_ready SHALL be 0.
REQ-021 in_ready SHALL equal !stall, driven combinationally.
REQ-022 A stage valid bit SHALL clear when the stage drains with no new beat entering behind it; bubbles SHALL propagate without producing out_valid.
REQ-023 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-024 out_result SHALL remain stable while out_valid && !out_ready.

Reset
REQ-025 While reset is high at a clock edge, all stage valid bits, out_valid and out_result SHALL become 0.
REQ-026 in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-027 Beats in flight when reset asserts SHALL be discarded and never appear at the output.
REQ-028 Reset SHALL take priority over simultaneous in_valid.

Configuration
REQ-029 Macro REDUCE_ACCUM_EN defined: an input port in_last (1 bit) SHALL be added.
REQ-030 Under REDUCE_ACCUM_EN, an accumulate stage SHALL follow the tree, adding 1 to the latency.
REQ-031 The accumulate stage SHALL combine per-beat results of one packet using the mode of the packet's first beat.
REQ-032 Under REDUCE_ACCUM_EN, out_valid SHALL assert only for the in_last beat of a packet.
REQ-033 Under REDUCE_ACCUM_EN, the accumulator SHALL reload to the identity value after the in_last beat and on reset.
REQ-034 Under REDUCE_ACCUM_EN, a single-beat packet (in_last=1 on the first beat) SHALL output that beat's result.
REQ-035 Macro REDUCE_ACCUM_EN undefined: in_last SHALL be absent, every beat SHALL produce an output, and latency SHALL be LEVELS.

Verification
REQ-036 WIDTH=32, mode 11, data 0x00000000 then 0x00010000 -> out_result 1 then 0, with out_valid on cycles 3 and 4 after the first acceptance.
REQ-037 WIDTH=32, mode 01, data 0xFFFFFFFF then 0xFFFFFFFE; mode 10, data 0x00000007 -> results 1, 0, 1 in order.
REQ-038 WIDTH=10, mode 01, data 0x3FF -> result 1, confirming padding identity.
REQ-039 Hold out_ready=0 for 5 cycles while feeding beats -> in_ready=0 throughout, out_result unchanged, no beat lost or duplicated.
REQ-040 Assert reset with 3 beats in flight -> out_valid stays 0, and the next accepted beat appears after LEVELS cycles.
REQ-041 With REDUCE_ACCUM_EN, mode 00, packet 0x0, 0x0, 0x8 (in_last on the third beat) -> exactly one output, result 1; then a single-beat packet 0x0 -> result 0.
